// File: rtl/dlx_pkg.sv
// Shared types for the DLX hazard/forwarding logic: register addresses and
// in-flight writer scoreboard entries.
package dlx_pkg;

    // Widest register address any instance may use; narrower fields are zero-extended.
    localparam int REG_AW_MAX = 8;

    typedef logic [REG_AW_MAX-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        logic      is_load;
    } sb_entry_t;

    localparam int        FWD_RF = 0;
    localparam reg_addr_t R0     = '0;

endpackage

// File: rtl/dlx_fwd_match.sv
// Matches one source operand against the writer scoreboard and returns the
// forwarding select of the youngest matching writer plus its load-use hazard.
module dlx_fwd_match
    import dlx_pkg::*;
#(
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic                      src_use_i,
    input  reg_addr_t                 src_i,
    input  sb_entry_t [FWD_DEPTH-1:0] entries_i,
    output logic [SEL_W-1:0]          sel_o,
    output logic                      load_hazard_o
);

    always_comb begin
        // NOTE: defaults first so every path assigns each output and no latch is inferred.
        sel_o         = SEL_W'(FWD_RF);
        load_hazard_o = 1'b0;
        // Scan oldest to youngest so the youngest matching writer assigns last and wins.
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (src_use_i && (src_i != R0) && entries_i[k-1].valid &&
                (entries_i[k-1].rd == src_i)) begin
                sel_o         = SEL_W'(k);
                load_hazard_o = entries_i[k-1].is_load && (k <= LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/dlx_hazard_unit.sv
// DLX hazard detection and forwarding: resettable in-flight writer scoreboard,
// load-use stall generation, per-operand forwarding selects and a stall counter.
module dlx_hazard_unit
    import dlx_pkg::*;
#(
    parameter  int REG_AW    = 5,
    parameter  int FWD_DEPTH = 2,
    parameter  int LOAD_LAT  = 1,
    localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_wr,
    input  logic              id_is_load,
    input  logic              id_is_store,
    input  logic              flush,
    input  logic              hold,
    output logic              stall,
    output logic              issue,
    output logic [SEL_W-1:0]  fwd_a_sel,
    output logic [SEL_W-1:0]  fwd_b_sel,
    output logic              store_fwd,
    output logic [15:0]       stall_cnt
);

    sb_entry_t [FWD_DEPTH-1:0] sb_q, sb_d;
    logic [15:0]               stall_cnt_q, stall_cnt_d;

    reg_addr_t rs1_ext, rs2_ext, rd_ext;
    logic      haz_a, haz_b;

    assign rs1_ext = REG_AW_MAX'(id_rs1);
    assign rs2_ext = REG_AW_MAX'(id_rs2);
    assign rd_ext  = REG_AW_MAX'(id_rd);

    dlx_fwd_match #(
        .FWD_DEPTH (FWD_DEPTH),
        .LOAD_LAT  (LOAD_LAT),
        .SEL_W     (SEL_W)
    ) u_match_a (
        .src_use_i     (id_use_rs1),
        .src_i         (rs1_ext),
        .entries_i     (sb_q),
        .sel_o         (fwd_a_sel),
        .load_hazard_o (haz_a)
    );

    dlx_fwd_match #(
        .FWD_DEPTH (FWD_DEPTH),
        .LOAD_LAT  (LOAD_LAT),
        .SEL_W     (SEL_W)
    ) u_match_b (
        .src_use_i     (id_use_rs2),
        .src_i         (rs2_ext),
        .entries_i     (sb_q),
        .sel_o         (fwd_b_sel),
        .load_hazard_o (haz_b)
    );

    // Flush and hold both override a hazard: nothing stalls that is being killed or frozen.
    assign stall     = id_valid & (haz_a | haz_b) & ~flush & ~hold;
    assign issue     = id_valid & ~stall & ~flush & ~hold;
    assign store_fwd = id_is_store & (fwd_b_sel != SEL_W'(FWD_RF));
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        sb_d        = sb_q;
        stall_cnt_d = stall_cnt_q;
        if (!hold) begin
            for (int k = 1; k < FWD_DEPTH; k++) begin
                sb_d[k] = sb_q[k-1];
            end
            // A stalled or flushed slot enters the scoreboard as an invalid bubble.
            sb_d[0].valid   = issue & id_reg_wr & (rd_ext != R0);
            sb_d[0].rd      = rd_ext;
            sb_d[0].is_load = id_is_load;
        end
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // NOTE: every scoreboard entry is reset; a stale writer surviving reset would
    // forward from a stage that holds no real instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so all state updates see the pre-edge values.
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: doc/dlx_hazard_unit.md
# dlx_hazard_unit

Parametrised hazard-detection and forwarding unit for the DLX pipeline. It replaces the fixed two-deep, unreset writer history with a resettable in-flight writer scoreboard of configurable depth and a configurable load-use latency. Each cycle it produces the stall, issue and per-operand forwarding selects for the instruction in ID. It sits beside the decoder: decode supplies operand and destination fields, and the EX/MEM datapath consumes the selects.

## Interface
- `REG_AW`, default 5: register address width.
- `FWD_DEPTH`, default 2: number of downstream stages tracked for forwarding, 1..4. Stage 1 is ID/EX→EX/MEM.
- `LOAD_LAT`, default 1: number of stages after issue during which a load result is not yet forwardable, 0..FWD_DEPTH-1.
- `SEL_W`, derived, $clog2(FWD_DEPTH+1): forwarding select width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs1`, `id_rs2` in REG_AW: source register fields.
- `id_use_rs1`, `id_use_rs2` in 1: operand is actually read (I-type clears rs2; store sets rs2 as store data).
- `id_rd` in REG_AW: destination after regDst/link resolution.
- `id_reg_wr` in 1: instruction writes the register file.
- `id_is_load` in 1: load, including LHI-style memory loads.
- `id_is_store` in 1: rs2 is store data rather than an ALU operand.
- `flush` in 1: taken branch or jump; kill the instruction in ID.
- `hold` in 1: global pipeline freeze (memory wait).
- `stall` out 1: hold PC and IF/ID and insert a bubble.
- `issue` out 1: the ID instruction advances into EX this cycle.
- `fwd_a_sel`, `fwd_b_sel` out SEL_W: 0 = register file; k = result of tracked stage k.
- `store_fwd` out 1: fwd_b_sel applies to store data (MEM-stage mux), not the ALU B input.
- `stall_cnt` out 16: saturating count of stall cycles.

## Operation
- Scoreboard: FWD_DEPTH entries, each holding {valid, rd, is_load}. Entry 1 is the youngest.
- A source matches entry k when all of the following hold: the source is used, entry k is valid, entry k rd equals the source, and the source is not r0. r0 never matches.
- Forwarding: the select is the smallest matching k (youngest writer wins). It is 0 when there is no match.
- Load-use hazard: a used source matches entry k with is_load=1 and k ≤ LOAD_LAT.
- stall = id_valid & hazard & ~flush & ~hold.
- issue = id_valid & ~stall & ~flush & ~hold.
- While stall is high, the fwd selects still reflect the current match. Consumers ignore them.
- store_fwd = id_is_store & (fwd_b_sel != 0).
- Shift, every cycle unless hold:
  - entry k ← entry k-1 for k ≥ 2.
  - entry 1 ← {issue & id_reg_wr & (id_rd != 0), id_rd, id_is_load}.
  - When issue=0, entry 1 becomes invalid (bubble).
- hold: the scoreboard is frozen, issue=0, stall=0, stall_cnt unchanged.
- flush with stall in the same cycle: flush wins. stall=0, a bubble is inserted, and stall_cnt does not increment.
- stall_cnt increments on each cycle with stall=1 and saturates at 16'hFFFF.

## Timing
- Reset (asynchronous, while rst_n=0): all entries invalid, stall_cnt=0. Outputs settle to stall=0, issue=id_valid&~flush&~hold, fwd selects 0, store_fwd=0.
- Reset mid-operation discards all in-flight writers. The first post-reset instruction sees no hazard.
- stall, issue, fwd_*, and store_fwd are combinational from the ID inputs plus registered state, with zero-cycle latency. The scoreboard and stall_cnt update on the rising edge.
- Load followed immediately by a dependent instruction, LOAD_LAT=1: one stall cycle. On the next cycle the load is in entry 2 and the select is 2.
- With LOAD_LAT=0 a load never stalls. With LOAD_LAT=L the stall lasts L+1-k cycles for a first match at entry k.
- A writer older than FWD_DEPTH stages is read from the register file. Write-before-read in the register file is required.

## Structure
- Shared package `dlx_pkg`:
  - `reg_addr_t`
  - scoreboard entry struct `sb_entry_t`
  - localparams `FWD_RF`=0, `R0`=0
- Sub-module `dlx_fwd_match`: one instance per source operand. It takes a source address, a use bit, and the entry vector, and returns {select, load_hazard}. Priority encoding is done inside it.

## Test plan
- Back-to-back ALU ops, FWD_DEPTH=2: ADD r3 then SUB r4,r3,r3 → fwd_a_sel=fwd_b_sel=1, stall=0. Two instructions later, a reader of r3 gets select 2. Three later, it gets select 0.
- LW r5 then ADD r6,r5,r1, LOAD_LAT=1 → stall=1 for exactly 1 cycle, stall_cnt=1, then issue=1 with fwd_a_sel=2. With LOAD_LAT=0 → no stall, fwd_a_sel=1.
- ADDI r0 followed by a reader of r0 → fwd selects 0 and no stall. Also: rs2 field equal to a pending rd with id_use_rs2=0 → fwd_b_sel=0.
- SW with store data r7 immediately after ADD r7 → fwd_b_sel=1, store_fwd=1, fwd_a_sel per base register.
- Load-use hazard in the same cycle as flush=1 → stall=0, issue=0, and entry 1 is invalid on the next cycle. Also: hold=1 for 3 cycles during a pending hazard → scoreboard unchanged and stall_cnt unchanged.
- Assert rst_n=0 asynchronously mid-stream with entries valid → selects immediately 0 and stall_cnt=0. Also: force 70000 stall cycles → stall_cnt holds at 16'hFFFF.
